text_console: RTL and testbench
===============================

TEXT_CONSOLE -- requirements
Module: text_console

Parameters
REQ-001 SHALL provide COLS, default 64, text columns; matches the 640-pixel / 10-pixel glyph grid.
REQ-002 SHALL provide ROWS, default 24, text rows; matches the 480-line / 20-line glyph grid.

Interface
REQ-003 SHALL have CLOCK_50  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have in_valid  input  1  byte offered.
REQ-006 SHALL have in_ready  output  1  byte can be accepted this cycle.
REQ-007 SHALL have in_char  input  8  byte to print or control code.
REQ-008 SHALL have fg_color  input  24  RGB foreground, sampled on accept.
REQ-009 SHALL have bg_color  input  24  RGB background, sampled on accept.
REQ-010 SHALL have charWr  output  1  one-cycle write strobe to the display character RAM.
REQ-011 SHALL have charWrFgColor, charWrBgColor  output  24 each  colours for the written cell.
REQ-012 SHALL have charWrCode  output  8  glyph code for the written cell.
REQ-013 SHALL have charWrX  output  6  column, and charWrY  output  5  row.
REQ-014 SHALL have cursor_x  output  6  and cursor_y  output  5  current cursor position.
REQ-015 SHALL have busy  output  1  high while clearing.

Function
REQ-016 SHALL implement two states: IDLE (in_ready=1) and CLEAR (in_ready=0, busy=1).
REQ-017 SHALL accept a byte when in_valid && in_ready, and only then.
REQ-018 SHALL register all charWr* outputs; a write caused by an accept appears on the cycle after the accept, with charWr high for exactly one cycle.
REQ-019 SHALL update cursor_x/cursor_y on the same edge that registers the write.
REQ-020 SHALL handle a printable byte (any code other than 0x08, 0x0A, 0x0C, 0x0D) as follows: write code, fg, bg at the cursor, then cursor_x+1.
REQ-021 SHALL, when a printable byte is written at cursor_x==COLS-1, set cursor_x=0 and cursor_y+1.
REQ-022 SHALL wrap cursor_y from ROWS-1 to 0; there is no scrolling.
REQ-023 SHALL handle 0x0A (LF) by setting cursor_x=0 and cursor_y+1 (with wrap), with no write.
REQ-024 SHALL handle 0x0D (CR) by setting cursor_x=0, with no write.
REQ-025 SHALL handle 0x08 (BS) as follows:
  - if cursor_x>0: cursor_x-1, then write 0x20 with the sampled fg/bg at the new position;
  - if cursor_x==0 and cursor_y>0: move to (COLS-1, cursor_y-1) and write 0x20 there;
  - at (0,0): no move and no write.
REQ-026 SHALL handle 0x0C (FF) by entering CLEAR on the accept edge and latching the sampled fg/bg as clear colours.
REQ-027 SHALL, in CLEAR, issue one write per cycle for COLS*ROWS consecutive cycles:
  - each write carries code 0x20 and the latched colours;
  - order is row-major from (0,0) to (COLS-1, ROWS-1);
  - the first write occurs on the cycle after the accept.
REQ-028 SHALL, on the edge that registers the final CLEAR write, set cursor to (0,0) and return to IDLE; in_ready=1 on the next cycle.
REQ-029 SHALL hold charWr=0 and leave charWrX/Y/Code/colours unchanged in any cycle with no write.
REQ-030 SHALL ignore in_valid and in_char while in CLEAR; no byte is lost because in_ready=0.
REQ-031 SHALL perform all position arithmetic modulo COLS/ROWS; charWrX < COLS and charWrY < ROWS always.

Reset
REQ-032 SHALL, while rst=1, force:
  - charWr=0, charWrX=0, charWrY=0, charWrCode=0, charWrFgColor=0, charWrBgColor=0;
  - cursor_x=0, cursor_y=0, in_ready=0, busy=1.
REQ-033 SHALL enter CLEAR after rst deasserts, with clear colours 0 (black), so the first write (0,0) occurs on the first cycle after rst falls.
REQ-034 SHALL, if rst asserts mid-CLEAR or mid-write, abandon the operation and restart the clear from (0,0) after deassertion.

Verification
REQ-035 SHALL cover reset release: exactly 1536 consecutive charWr pulses, code 0x20, colours 0, addresses (0,0)..(63,23) in order; then in_ready=1, cursor (0,0).
REQ-036 SHALL cover printing: 'A' (0x41, fg 0xFFFFFF, bg 0x000080) at (63,5) -> write (63,5) code 0x41 one cycle after accept; cursor becomes (0,6).
REQ-037 SHALL cover wrap: printable at (63,23) -> write (63,23); cursor (0,0). LF at y=23 -> cursor (0,0), no charWr.
REQ-038 SHALL cover backspace: BS at (0,3) -> cursor (63,2), write 0x20 at (63,2). BS at (0,0) -> no write, cursor unchanged.
REQ-039 SHALL cover clear: FF with bg 0x112233 at cursor (10,10) -> in_ready=0 for 1536 cycles, all writes use bg 0x112233; in_valid held high meanwhile causes no accept; cursor (0,0) after.
REQ-040 SHALL cover reset mid-clear: rst for 1 cycle at write index 700 -> sequence restarts at (0,0) with colours 0 and completes all 1536 writes.

Source files
------------

// File: rtl/text_console.sv
// Streaming text console: turns a byte stream into character-RAM cell writes,
// tracks the cursor and runs a full-screen clear on form feed and after reset.
module text_console #(
    parameter int COLS = 64,
    parameter int ROWS = 24
) (
    input  logic        CLOCK_50,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_char,
    input  logic [23:0] fg_color,
    input  logic [23:0] bg_color,
    output logic        charWr,
    output logic [23:0] charWrFgColor,
    output logic [23:0] charWrBgColor,
    output logic [7:0]  charWrCode,
    output logic [5:0]  charWrX,
    output logic [4:0]  charWrY,
    output logic [5:0]  cursor_x,
    output logic [4:0]  cursor_y,
    output logic        busy
);

    localparam logic [5:0] X_MAX = 6'(COLS - 1);
    localparam logic [4:0] Y_MAX = 5'(ROWS - 1);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t      state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;
    logic        wr_q, wr_d;
    logic [5:0]  wr_x_q, wr_x_d;
    logic [4:0]  wr_y_q, wr_y_d;
    logic [7:0]  wr_code_q, wr_code_d;
    logic [23:0] wr_fg_q, wr_fg_d;
    logic [23:0] wr_bg_q, wr_bg_d;
    logic [5:0]  cursor_x_q, cursor_x_d;
    logic [4:0]  cursor_y_q, cursor_y_d;
    logic [5:0]  clr_x_q, clr_x_d;
    logic [4:0]  clr_y_q, clr_y_d;
    logic [23:0] clr_fg_q, clr_fg_d;
    logic [23:0] clr_bg_q, clr_bg_d;
    logic        accept;
    logic [4:0]  next_row;

    assign accept   = in_valid && in_ready_q;
    assign next_row = (cursor_y_q == Y_MAX) ? 5'd0 : cursor_y_q + 5'd1;

    always_comb begin
        state_d    = state_q;
        wr_d       = 1'b0;
        wr_x_d     = wr_x_q;
        wr_y_d     = wr_y_q;
        wr_code_d  = wr_code_q;
        wr_fg_d    = wr_fg_q;
        wr_bg_d    = wr_bg_q;
        cursor_x_d = cursor_x_q;
        cursor_y_d = cursor_y_q;
        clr_x_d    = clr_x_q;
        clr_y_d    = clr_y_q;
        clr_fg_d   = clr_fg_q;
        clr_bg_d   = clr_bg_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (in_char)
                        8'h0A: begin
                            cursor_x_d = 6'd0;
                            cursor_y_d = next_row;
                        end
                        8'h0D: cursor_x_d = 6'd0;
                        8'h08: begin
                            if (cursor_x_q != 6'd0) begin
                                cursor_x_d = cursor_x_q - 6'd1;
                                wr_d       = 1'b1;
                                wr_x_d     = cursor_x_q - 6'd1;
                                wr_y_d     = cursor_y_q;
                                wr_code_d  = 8'h20;
                                wr_fg_d    = fg_color;
                                wr_bg_d    = bg_color;
                            end else if (cursor_y_q != 5'd0) begin
                                cursor_x_d = X_MAX;
                                cursor_y_d = cursor_y_q - 5'd1;
                                wr_d       = 1'b1;
                                wr_x_d     = X_MAX;
                                wr_y_d     = cursor_y_q - 5'd1;
                                wr_code_d  = 8'h20;
                                wr_fg_d    = fg_color;
                                wr_bg_d    = bg_color;
                            end
                        end
                        8'h0C: begin
                            state_d  = S_CLEAR;
                            clr_x_d  = 6'd0;
                            clr_y_d  = 5'd0;
                            clr_fg_d = fg_color;
                            clr_bg_d = bg_color;
                        end
                        default: begin
                            wr_d      = 1'b1;
                            wr_x_d    = cursor_x_q;
                            wr_y_d    = cursor_y_q;
                            wr_code_d = in_char;
                            wr_fg_d   = fg_color;
                            wr_bg_d   = bg_color;
                            if (cursor_x_q == X_MAX) begin
                                cursor_x_d = 6'd0;
                                cursor_y_d = next_row;
                            end else begin
                                cursor_x_d = cursor_x_q + 6'd1;
                            end
                        end
                    endcase
                end
            end
            S_CLEAR: begin
                // One blank cell per cycle, row-major; the last cell homes the cursor.
                wr_d      = 1'b1;
                wr_x_d    = clr_x_q;
                wr_y_d    = clr_y_q;
                wr_code_d = 8'h20;
                wr_fg_d   = clr_fg_q;
                wr_bg_d   = clr_bg_q;
                if (clr_x_q == X_MAX) begin
                    clr_x_d = 6'd0;
                    if (clr_y_q == Y_MAX) begin
                        clr_y_d    = 5'd0;
                        state_d    = S_IDLE;
                        cursor_x_d = 6'd0;
                        cursor_y_d = 5'd0;
                    end else begin
                        clr_y_d = clr_y_q + 5'd1;
                    end
                end else begin
                    clr_x_d = clr_x_q + 6'd1;
                end
            end
            default: state_d = S_CLEAR;
        endcase

        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d == S_CLEAR);
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_q    <= S_CLEAR;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            wr_q       <= 1'b0;
            wr_x_q     <= 6'd0;
            wr_y_q     <= 5'd0;
            wr_code_q  <= 8'd0;
            wr_fg_q    <= 24'd0;
            wr_bg_q    <= 24'd0;
            cursor_x_q <= 6'd0;
            cursor_y_q <= 5'd0;
            clr_x_q    <= 6'd0;
            clr_y_q    <= 5'd0;
            clr_fg_q   <= 24'd0;
            clr_bg_q   <= 24'd0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            wr_q       <= wr_d;
            wr_x_q     <= wr_x_d;
            wr_y_q     <= wr_y_d;
            wr_code_q  <= wr_code_d;
            wr_fg_q    <= wr_fg_d;
            wr_bg_q    <= wr_bg_d;
            cursor_x_q <= cursor_x_d;
            cursor_y_q <= cursor_y_d;
            clr_x_q    <= clr_x_d;
            clr_y_q    <= clr_y_d;
            clr_fg_q   <= clr_fg_d;
            clr_bg_q   <= clr_bg_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign busy          = busy_q;
    assign charWr        = wr_q;
    assign charWrX       = wr_x_q;
    assign charWrY       = wr_y_q;
    assign charWrCode    = wr_code_q;
    assign charWrFgColor = wr_fg_q;
    assign charWrBgColor = wr_bg_q;
    assign cursor_x      = cursor_x_q;
    assign cursor_y      = cursor_y_q;

endmodule

// File: tb/tb_text_console.sv
// Bench for text_console: table-driven byte vectors plus clear / wrap / reset
// sequences, with every expected cell write queued in a scoreboard.
module tb_text_console;

    logic        CLOCK_50 = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_char = 8'd0;
    logic [23:0] fg_color = 24'd0;
    logic [23:0] bg_color = 24'd0;
    logic        charWr;
    logic [23:0] charWrFgColor, charWrBgColor;
    logic [7:0]  charWrCode;
    logic [5:0]  charWrX;
    logic [4:0]  charWrY;
    logic [5:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        busy;

    text_console dut (
        .CLOCK_50      (CLOCK_50),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_char       (in_char),
        .fg_color      (fg_color),
        .bg_color      (bg_color),
        .charWr        (charWr),
        .charWrFgColor (charWrFgColor),
        .charWrBgColor (charWrBgColor),
        .charWrCode    (charWrCode),
        .charWrX       (charWrX),
        .charWrY       (charWrY),
        .cursor_x      (cursor_x),
        .cursor_y      (cursor_y),
        .busy          (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [5:0]  x;
        logic [4:0]  y;
        logic [7:0]  code;
        logic [23:0] fg;
        logic [23:0] bg;
    } wr_t;

    typedef struct {
        logic [7:0]  ch;
        logic [23:0] fg;
        logic [23:0] bg;
        bit          wr;
        logic [5:0]  wx;
        logic [4:0]  wy;
        logic [7:0]  wcode;
        logic [5:0]  cx;
        logic [4:0]  cy;
    } vec_t;

    wr_t  sb[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   pops = 0;

    function automatic wr_t mkWr(int x, int y, logic [7:0] c, logic [23:0] f, logic [23:0] b);
        wr_t w;
        w.x = 6'(x);
        w.y = 5'(y);
        w.code = c;
        w.fg = f;
        w.bg = b;
        return w;
    endfunction

    function automatic vec_t mkVec(logic [7:0] ch, logic [23:0] f, logic [23:0] b, bit wr,
                                   int wx, int wy, logic [7:0] wc, int cx, int cy);
        vec_t v;
        v.ch = ch; v.fg = f; v.bg = b; v.wr = wr;
        v.wx = 6'(wx); v.wy = 5'(wy); v.wcode = wc;
        v.cx = 6'(cx); v.cy = 5'(cy);
        return v;
    endfunction

    // Every write the DUT issues must match the oldest queued expectation.
    always @(negedge CLOCK_50) begin
        if (charWr === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write: got x=%0d y=%0d code=%h, expected no write",
                         charWrX, charWrY, charWrCode);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if ({charWrX, charWrY, charWrCode, charWrFgColor, charWrBgColor} !== e) begin
                    errors++;
                    $display("[TB] FAIL write%0d: got x=%0d y=%0d code=%h fg=%h bg=%h, expected x=%0d y=%0d code=%h fg=%h bg=%h",
                             pops, charWrX, charWrY, charWrCode, charWrFgColor, charWrBgColor,
                             e.x, e.y, e.code, e.fg, e.bg);
                end
            end
            pops++;
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pushClear(input logic [23:0] f, input logic [23:0] b);
        for (int y = 0; y < 24; y++)
            for (int x = 0; x < 64; x++)
                sb.push_back(mkWr(x, y, 8'h20, f, b));
    endtask

    task automatic applyStimulus(input logic [7:0] ch, input logic [23:0] f, input logic [23:0] b);
        checkOutput("ready_before_drive", int'(in_ready), 1);
        in_valid = 1'b1;
        in_char  = ch;
        fg_color = f;
        bg_color = b;
        @(posedge CLOCK_50);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic runVec(input vec_t v, input string tag);
        if (v.wr) sb.push_back(mkWr(int'(v.wx), int'(v.wy), v.wcode, v.fg, v.bg));
        applyStimulus(v.ch, v.fg, v.bg);
        @(negedge CLOCK_50);
        #1;
        checkOutput({tag, "_cx"}, int'(cursor_x), int'(v.cx));
        checkOutput({tag, "_cy"}, int'(cursor_y), int'(v.cy));
        checkOutput({tag, "_sb"}, sb.size(), 0);
    endtask

    // Counts busy cycles until in_ready rises; in_valid is dropped the moment it does.
    task automatic waitReady(output int n, input bit jitter);
        n = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge CLOCK_50);
            if (in_ready === 1'b1) begin
                in_valid = 1'b0;
                return;
            end
            n++;
            if (jitter) in_char = 8'($urandom_range(255));
        end
        in_valid = 1'b0;
        checks++;
        errors++;
        $display("[TB] FAIL ready_timeout: got in_ready=%0b after %0d cycles, expected 1", in_ready, n);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_charWr"}, int'(charWr), 0);
        checkOutput({tag, "_wrXY"}, int'({charWrX, charWrY}), 0);
        checkOutput({tag, "_wrCode"}, int'(charWrCode), 0);
        checkOutput({tag, "_wrFg"}, int'(charWrFgColor), 0);
        checkOutput({tag, "_wrBg"}, int'(charWrBgColor), 0);
        checkOutput({tag, "_cursor"}, int'({cursor_x, cursor_y}), 0);
        checkOutput({tag, "_in_ready"}, int'(in_ready), 0);
        checkOutput({tag, "_busy"}, int'(busy), 1);
    endtask

    initial begin
        int n;
        int base;
        localparam logic [23:0] W = 24'hFFFFFF;

        vecs.push_back(mkVec(8'h08, W, 24'h0, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mkVec(8'h48, W, 24'h0, 1, 0, 0, 8'h48, 1, 0));
        vecs.push_back(mkVec(8'h69, 24'h00FF00, 24'h000010, 1, 1, 0, 8'h69, 2, 0));
        vecs.push_back(mkVec(8'h08, 24'h123456, 24'h654321, 1, 1, 0, 8'h20, 1, 0));
        vecs.push_back(mkVec(8'h0D, W, 24'h0, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mkVec(8'h0A, W, 24'h0, 0, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mkVec(8'h0A, W, 24'h0, 0, 0, 0, 8'h00, 0, 2));
        vecs.push_back(mkVec(8'h0A, W, 24'h0, 0, 0, 0, 8'h00, 0, 3));
        vecs.push_back(mkVec(8'h08, 24'hA0A0A0, 24'h0B0B0B, 1, 63, 2, 8'h20, 63, 2));
        vecs.push_back(mkVec(8'h42, W, 24'h0, 1, 63, 2, 8'h42, 0, 3));
        vecs.push_back(mkVec(8'h09, W, 24'h0, 1, 0, 3, 8'h09, 1, 3));
        vecs.push_back(mkVec(8'h0D, W, 24'h0, 0, 0, 0, 8'h00, 0, 3));
        vecs.push_back(mkVec(8'h0A, W, 24'h0, 0, 0, 0, 8'h00, 0, 4));
        vecs.push_back(mkVec(8'h0A, W, 24'h0, 0, 0, 0, 8'h00, 0, 5));
        vecs.push_back(mkVec(8'h0A, W, 24'h0, 0, 0, 0, 8'h00, 0, 6));
        vecs.push_back(mkVec(8'h08, W, 24'h0, 1, 63, 5, 8'h20, 63, 5));
        vecs.push_back(mkVec(8'h41, W, 24'h000080, 1, 63, 5, 8'h41, 0, 6));
        vecs.push_back(mkVec(8'h0E, W, 24'h0, 1, 0, 6, 8'h0E, 1, 6));
        vecs.push_back(mkVec(8'h0B, W, 24'h0, 1, 1, 6, 8'h0B, 2, 6));
        vecs.push_back(mkVec(8'h0D, W, 24'h0, 0, 0, 0, 8'h00, 0, 6));

        // Reset hold and release: full black clear.
        repeat (3) @(posedge CLOCK_50);
        #1;
        checkResetState("reset");
        pushClear(24'h0, 24'h0);
        rst = 1'b0;
        waitReady(n, 1'b0);
        #1;
        checkOutput("reset_clear_cycles", n, 1536);
        checkOutput("reset_clear_writes", pops, 1536);
        checkOutput("reset_clear_sb", sb.size(), 0);
        checkOutput("reset_cursor", int'({cursor_x, cursor_y}), 0);
        checkOutput("reset_in_ready", int'(in_ready), 1);

        foreach (vecs[i]) runVec(vecs[i], $sformatf("vec%0d", i));

        // Walk down to the bottom row, then LF wraps to the top without writing.
        for (int y = 7; y <= 23; y++)
            runVec(mkVec(8'h0A, W, 24'h0, 0, 0, 0, 8'h00, 0, y), "lf_down");
        runVec(mkVec(8'h0A, W, 24'h0, 0, 0, 0, 8'h00, 0, 0), "lf_wrap");
        for (int y = 1; y <= 23; y++)
            runVec(mkVec(8'h0A, W, 24'h0, 0, 0, 0, 8'h00, 0, y), "lf_down2");
        for (int x = 0; x < 63; x++)
            runVec(mkVec(8'h61, 24'h00FFFF, 24'h200000, 1, x, 23, 8'h61, x + 1, 23), "row23");
        runVec(mkVec(8'h7E, 24'h00FFFF, 24'h200000, 1, 63, 23, 8'h7E, 0, 0), "wrap_corner");

        // Position to (10,10) and form-feed with in_valid held high throughout the clear.
        for (int y = 1; y <= 10; y++)
            runVec(mkVec(8'h0A, W, 24'h0, 0, 0, 0, 8'h00, 0, y), "lf_to10");
        for (int x = 0; x < 10; x++)
            runVec(mkVec(8'h78, W, 24'h0, 1, x, 10, 8'h78, x + 1, 10), "x_to10");
        pushClear(24'hC0FFEE, 24'h112233);
        base = pops;
        applyStimulus(8'h0C, 24'hC0FFEE, 24'h112233);
        in_valid = 1'b1;
        in_char  = 8'h41;
        waitReady(n, 1'b1);
        #1;
        checkOutput("ff_busy_cycles", n, 1536);
        checkOutput("ff_writes", pops - base, 1536);
        checkOutput("ff_sb", sb.size(), 0);
        checkOutput("ff_cursor", int'({cursor_x, cursor_y}), 0);
        checkOutput("ff_busy_low", int'(busy), 0);

        // Reset at write index 700 of a coloured clear restarts a black clear from (0,0).
        pushClear(24'hABCDEF, 24'h445566);
        base = pops;
        applyStimulus(8'h0C, 24'hABCDEF, 24'h445566);
        for (int i = 0; i < 4000 && (pops - base) < 700; i++) begin
            @(negedge CLOCK_50);
            #1;
        end
        checkOutput("midclr_reached", pops - base, 700);
        rst = 1'b1;
        sb.delete();
        pushClear(24'h0, 24'h0);
        @(posedge CLOCK_50);
        #1;
        checkResetState("midclr_reset");
        rst = 1'b0;
        base = pops;
        waitReady(n, 1'b0);
        #1;
        checkOutput("midclr_cycles", n, 1536);
        checkOutput("midclr_writes", pops - base, 1536);
        checkOutput("midclr_sb", sb.size(), 0);
        checkOutput("midclr_cursor", int'({cursor_x, cursor_y}), 0);

        repeat (4) @(negedge CLOCK_50);
        #1;
        checkOutput("final_sb", sb.size(), 0);
        checkOutput("final_in_ready", int'(in_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
